// File: rtl/aes_inv_subbytes_seq_if.sv
// Handshake bundle for the InvSubBytes stage.
//   in_valid/in_ready/state_in    : upstream state transfer (from InvShiftRows)
//   out_valid/out_ready/state_out : downstream result transfer (to AddRoundKey)
//   busy                          : stage is not idle
// master = the side that supplies states and consumes results; slave = the stage.
interface aes_inv_subbytes_seq_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  modport master (
    output in_valid, state_in, out_ready,
    input  in_ready, out_valid, state_out, busy
  );

  modport slave (
    input  in_valid, state_in, out_ready,
    output in_ready, out_valid, state_out, busy
  );
endinterface

// File: rtl/aes_inv_subbytes_seq.sv
// AES InvSubBytes over a 128-bit state, time-multiplexed across LANES
// inverse-S-box ROMs with a registered (BRAM-style) one-cycle read.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : aes_inv_subbytes_seq_if.slave (valid/ready in, valid/ready out, busy)
// Byte i of a state lives at [127-8i -: 8]; byte 0 is the MSB byte.

// Inverse S-box ROM, one registered read port. Output register is not reset.
module aes_inv_sbox_bram (
  input  logic       clk,
  input  logic [7:0] addr,
  output logic [7:0] dout
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  logic [7:0]  dout_q;
  logic [10:0] idx;

  assign idx = 11'd2047 - {addr, 3'b000};

  always_ff @(posedge clk) begin
    dout_q <= INV_SBOX[idx -: 8];
  end

  assign dout = dout_q;
endmodule

module aes_inv_subbytes_seq #(
  parameter int unsigned LANES = 4
) (
  input logic                  clk,
  input logic                  rst,
  aes_inv_subbytes_seq_if.slave bus
);
  localparam int unsigned BEATS = 16 / LANES;
  localparam int unsigned CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
    $error("aes_inv_subbytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  cap_q, cap_d;
  logic           pend_q, pend_d;
  logic [127:0]   in_q, in_d;
  logic [127:0]   res_q, res_d;
  logic           ov_q, ov_d;

  logic [7:0] rom_addr [LANES];
  logic [7:0] rom_dout [LANES];

  // LSB position of byte (beat*LANES + lane); 15-k equals ~k in 4 bits.
  function automatic logic [6:0] byte_lsb(input logic [CW-1:0] beat, input int unsigned lane);
    logic [3:0] k;
    k = 4'(32'(beat) * LANES + lane);
    return {~k, 3'b000};
  endfunction

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    aes_inv_sbox_bram u_rom (
      .clk  (clk),
      .addr (rom_addr[j]),
      .dout (rom_dout[j])
    );
  end

  always_comb begin
    for (int unsigned j = 0; j < LANES; j++) begin
      rom_addr[j] = in_q[byte_lsb(cnt_q, j) +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    pend_d  = pend_q;
    in_d    = in_q;
    res_d   = res_q;
    ov_d    = ov_q;

    // ROM data on this edge belongs to the beat issued one cycle earlier.
    if ((state_q == RUN || state_q == DRAIN) && pend_q) begin
      for (int unsigned j = 0; j < LANES; j++) begin
        res_d[byte_lsb(cap_q, j) +: 8] = rom_dout[j];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          in_d    = bus.state_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        pend_d = 1'b1;
        cap_d  = cnt_q;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(BEATS - 1)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        pend_d  = 1'b0;
        ov_d    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          ov_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cap_q   <= '0;
      pend_q  <= 1'b0;
      in_q    <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      pend_q  <= pend_d;
      in_q    <= in_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.out_valid = ov_q;
  assign bus.state_out = res_q;
endmodule

// File: doc/aes_inv_subbytes_seq.md
Name: aes_inv_subbytes_seq

Overview:
Decrypt-side InvSubBytes stage for the AES datapath. It takes one 128-bit state and applies the AES inverse S-box to all 16 bytes. The work is time-multiplexed over LANES inverse-S-box ROM instances that have a registered 1-cycle read (BRAM style). Input and output use valid/ready handshakes; it sits between InvShiftRows and AddRoundKey in the decryption round loop.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; BEATS = 16/LANES.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  state_in holds a valid state
in_ready  output  1  block can accept a state
state_in  input  128  ciphertext-side state; byte i = state_in[127-8i -: 8], byte 0 is the MSB byte
out_valid  output  1  state_out holds a valid result
out_ready  input  1  downstream accepts the result
state_out  output  128  InvSubBytes(state_in), same byte ordering
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert on rst=1): state=IDLE, beat counter=0, capture-pending flag=0, out_valid=0, state_out=0, busy=0, in_ready=1 once rst deasserts.
- ROM output registers are not reset. They are only consumed when the capture-pending flag is set.
- Internal sub-blocks: LANES instances of aes_inv_sbox_bram (ports clk, addr[7:0], dout[7:0]; dout = InvSbox(addr) one edge after addr is presented).
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: in_ready=1. On an edge with in_valid=1, latch state_in into an input register, set cnt=0, go to RUN.
- RUN: in_ready=0. Lane j ROM address = input byte cnt*LANES+j.
  - Each edge: capture-pending flag <= 1 and captured beat index <= cnt, then cnt++.
  - If capture-pending is already set, ROM dout of the previously issued beat is written into the result bytes for that beat.
  - When cnt=BEATS-1 at an edge, go to DRAIN.
- DRAIN: one cycle. The last beat is written at the edge, capture-pending is cleared, state goes to DONE, out_valid <= 1.
- Latency: out_valid rises BEATS+1 edges after the accept edge (5 for LANES=4, 2 for LANES=16).
- DONE: out_valid=1. state_out and out_valid are held stable while out_ready=0. On an edge with out_ready=1, out_valid <= 0 and state goes to IDLE.
- state_out keeps its last value after the handshake until the next block's first capture.
- in_valid is ignored outside IDLE. Holding in_valid does not cause a double accept.
- Throughput with out_ready held high: one state per BEATS+3 cycles (accept, BEATS RUN, DRAIN, DONE).
- Reset mid-operation (any state): async return to reset values; the partial result is discarded. The first state accepted after reset must be bit-exact.
- Non-power-of-two LANES: elaboration error.

Test Plan:
- 1. state_in=0x63 repeated 16 times, LANES=4, out_ready=1 -> state_out=0x00…00; out_valid rises exactly 5 edges after the accept edge, high for 1 cycle.
- 2. state_in=000102030405060708090A0B0C0D0E0F -> state_out=52096AD53036A538BF40A39E81F3D7FB (checks byte ordering per lane and beat).
- 3. state_in=638293C31BFC33F5C4EEACEA4BC12816 -> state_out=00112233445566778899AABBCCDDEEFF (round trip against encrypt-side SubBytes).
- 4. Backpressure: out_ready=0 for 10 cycles in DONE while in_valid=1 with a new state -> out_valid=1, state_out unchanged, in_ready=0, new state not accepted until 1 cycle after the out handshake.
- 5. Assert rst during RUN at cnt=2 -> out_valid=0, state_out=0, busy=0 immediately (async); after release, vector 2 yields the correct result with nominal latency.
- 6. LANES=16 and LANES=1 builds: vector 3 -> same result with latency 2 and 17 edges respectively; back-to-back in_valid with out_ready=1 accepts every BEATS+3 cycles.
